// File: rtl/reg_bank_scroll.sv
// Parametrised register bank with indexed write, registered read, flat readout,
// one-cycle downward scroll and a sequenced one-entry-per-cycle clear.
module reg_bank_scroll #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Load,
    input  logic [IDX_W-1:0]       Index,
    input  logic [WIDTH-1:0]       D,
    input  logic                   Shift,
    input  logic [WIDTH-1:0]       ShiftIn,
    input  logic                   Clear,
    input  logic [IDX_W-1:0]       RdIdx,
    output logic [WIDTH-1:0]       RdData,
    output logic [DEPTH*WIDTH-1:0] Q,
    output logic                   Busy,
    output logic                   ClearDone
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] nxt_val [DEPTH];
    logic [WIDTH-1:0] rd_val;

    // Shift first, then Load overrides the post-shift value at its index.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [WIDTH-1:0] shifted;
        if (i == DEPTH - 1) begin : g_top
            assign shifted = ShiftIn;
        end else begin : g_mid
            assign shifted = mem_q[i+1];
        end
        assign nxt_val[i] = (Load && Index == IDX_W'(i)) ? D :
                            (Shift ? shifted : mem_q[i]);
        assign Q[i*WIDTH +: WIDTH] = mem_q[i];
    end

    // Out-of-range read indices fall through to zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RdIdx == IDX_W'(i)) rd_val = mem_q[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            Busy      <= 1'b0;
            ClearDone <= 1'b0;
            RdData    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            RdData    <= rd_val;
            ClearDone <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Clear) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                        Busy    <= 1'b1;
                    end else begin
                        for (int i = 0; i < DEPTH; i++) mem_q[i] <= nxt_val[i];
                    end
                end
                StClear: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (ptr_q == IDX_W'(i)) mem_q[i] <= '0;
                    end
                    if (ptr_q == LastIdx) begin
                        state_q   <= StIdle;
                        ptr_q     <= '0;
                        Busy      <= 1'b0;
                        ClearDone <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
